// File: rtl/mips32_pkg.sv
// Shared constants and the fetch-queue entry type for the MIPS32 front end.
package mips32_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          IF_DEPTH  = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
        logic        misalign;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order circular buffer of fetched words: tail allocate, fill oldest
// unfilled entry, pop from head, synchronous clear.
module fetch_queue
    import mips32_pkg::*;
#(
    parameter  int DEPTH = IF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i_clear,
    input  logic          i_alloc,
    input  fetch_entry_t  i_alloc_entry,
    input  logic          i_fill,
    input  logic [31:0]   i_fill_data,
    input  logic          i_pop,
    output logic [CW-1:0] o_count,
    output fetch_entry_t  o_head
);

    logic [AW-1:0]    r_head;
    logic [AW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic [DEPTH-1:0] r_filled;
    logic [DEPTH-1:0] r_misalign;
    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_instr [DEPTH];

    logic [AW-1:0]    w_fill_idx;
    logic             w_fill_hit;
    logic             w_fill_en;

    // Responses return in request order, so the target is the first
    // allocated-but-unfilled slot walking forward from the head.
    // NOTE: every always_comb output gets a default before the loop, otherwise
    // the "not found" path would infer a latch.
    always_comb begin
        w_fill_idx = r_head;
        w_fill_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_fill_hit && (CW'(i) < r_count) && !r_filled[r_head + AW'(i)]) begin
                w_fill_hit = 1'b1;
                w_fill_idx = r_head + AW'(i);
            end
        end
    end

    assign w_fill_en = i_fill & w_fill_hit;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_filled <= '0;
        end else if (i_clear) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_filled <= '0;
        end else begin
            if (i_alloc) begin
                r_filled[r_tail] <= i_alloc_entry.filled;
                r_tail           <= r_tail + AW'(1);
            end
            if (w_fill_en) begin
                r_filled[w_fill_idx] <= 1'b1;
            end
            if (i_pop) begin
                r_head <= r_head + AW'(1);
            end
            r_count <= r_count + CW'(i_alloc) - CW'(i_pop);
        end
    end

    // NOTE: payload storage is deliberately not reset; a slot is only ever
    // observed once its reset-cleared filled flag has been set.
    always_ff @(posedge clock) begin
        if (i_alloc && !i_clear) begin
            r_pc[r_tail]       <= i_alloc_entry.pc;
            r_instr[r_tail]    <= i_alloc_entry.instr;
            r_misalign[r_tail] <= i_alloc_entry.misalign;
        end
        if (w_fill_en && !i_clear) begin
            r_instr[w_fill_idx] <= i_fill_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = '{pc:       r_pc[r_head],
                       instr:    r_instr[r_head],
                       filled:   (r_count != '0) && r_filled[r_head],
                       misalign: r_misalign[r_head]};

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: issues word reads for the current PC, tracks
// in-flight responses and redirect discards, and feeds decode in order.
module if_stage
    import mips32_pkg::fetch_entry_t, mips32_pkg::NOP_INSTR, mips32_pkg::IF_DEPTH;
#(
    parameter int          DEPTH    = IF_DEPTH,
    parameter logic [31:0] RESET_PC = mips32_pkg::RESET_PC
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] pc,
    output logic        pc_enable,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        if_misalign,
    input  logic        id_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic          r_run;
    logic [CW-1:0] r_outstanding;
    logic [CW-1:0] r_discard;

    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_alloc_entry;
    logic          w_flush;
    logic          w_aligned;
    logic          w_space;
    logic          w_can_alloc;
    logic          w_accept;
    logic          w_misalign_alloc;
    logic          w_alloc;
    logic          w_rsp;
    logic          w_drop;
    logic          w_fill;
    logic          w_head_valid;
    logic          w_pop;

    // r_run holds issue and pc_enable low until the first edge after reset
    // release, so both fall asynchronously with reset_n.
    assign w_flush   = flush & r_run;
    assign w_aligned = (pc[1:0] == 2'b00);

    // Slots still owed a discarded response count against capacity.
    assign w_space = ((CW+1)'(w_count) + (CW+1)'(r_discard)) < (CW+1)'(DEPTH);

    assign w_can_alloc      = r_run & ~flush & w_space;
    assign imem_req         = w_can_alloc & w_aligned;
    assign imem_addr        = {pc[31:2], 2'b00};
    assign w_accept         = imem_req & imem_ready;
    assign w_misalign_alloc = w_can_alloc & ~w_aligned;
    assign w_alloc          = w_accept | w_misalign_alloc;
    assign pc_enable        = w_alloc | w_flush;

    assign w_alloc_entry = '{pc:       pc,
                             instr:    NOP_INSTR,
                             filled:   w_misalign_alloc,
                             misalign: w_misalign_alloc};

    assign w_rsp  = imem_rvalid & (r_outstanding != '0);
    assign w_drop = w_rsp & (r_discard != '0);
    assign w_fill = w_rsp & (r_discard == '0) & ~w_flush;

    assign w_head_valid = w_head.filled;
    assign w_pop        = w_head_valid & id_ready & ~w_flush;

    // On redirect every request still in flight becomes a discard; a response
    // landing in the flush cycle has already returned and is not counted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_run         <= 1'b0;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(w_rsp);
            if (w_flush) begin
                r_discard <= r_outstanding - CW'(w_rsp);
            end else if (w_drop) begin
                r_discard <= r_discard - CW'(1);
            end
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_fetch_queue (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_clear       (w_flush),
        .i_alloc       (w_alloc),
        .i_alloc_entry (w_alloc_entry),
        .i_fill        (w_fill),
        .i_fill_data   (imem_rdata),
        .i_pop         (w_pop),
        .o_count       (w_count),
        .o_head        (w_head)
    );

    assign if_valid    = w_head_valid;
    assign if_instr    = w_head_valid ? w_head.instr : '0;
    assign if_pc       = w_head_valid ? w_head.pc : RESET_PC;
    assign if_pc4      = w_head_valid ? (w_head.pc + 32'd4) : '0;
    assign if_misalign = w_head_valid & w_head.misalign;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a PC-register model and an in-order
// instruction memory of programmable latency (data = ~address).
module tb_if_stage;

    logic        clock;
    logic        reset_n;
    logic [31:0] pc;
    logic        pc_enable;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        mem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        if_misalign;
    logic        id_ready;

    logic [31:0] pc_init;
    logic [31:0] flush_target;
    int          lat;
    int          cyc;
    int          mem_accepts;
    int          checks;
    int          errors;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    if_stage dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pc          (pc),
        .pc_enable   (pc_enable),
        .flush       (flush),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (mem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc4      (if_pc4),
        .if_misalign (if_misalign),
        .id_ready    (id_ready)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // PC register: advance on accept, load the redirect target on flush.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)       pc <= pc_init;
        else if (pc_enable) pc <= flush ? flush_target : pc + 32'd4;
    end

    // Memory: a request accepted at cycle c responds during the cycle after
    // edge c+lat-1, one response per cycle, in order. Shares reset_n.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend.delete();
            imem_rvalid <= 1'b0;
            imem_rdata  <= '0;
            cyc         <= 0;
            mem_accepts <= 0;
        end else begin
            if (imem_rvalid && pend.size() > 0) pend.pop_front();
            if (imem_req && mem_ready) begin
                pend.push_back('{imem_addr, cyc + lat - 1});
                mem_accepts <= mem_accepts + 1;
            end
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= ~pend[0].addr;
            end else begin
                imem_rvalid <= 1'b0;
            end
            cyc <= cyc + 1;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [31:0] pc0, input int lat0);
        reset_n  = 1'b0;
        pc_init  = pc0;
        lat      = lat0;
        flush    = 1'b0;
        id_ready = 1'b1;
        mem_ready = 1'b1;
        flush_target = '0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input int max_cycles, input string tag);
        int n = 0;
        while (!if_valid && n < max_cycles) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 32'(if_valid), 32'd1);
    endtask

    // Observes deliveries until count words match, checking each in order.
    task automatic collect(input logic [31:0] first_pc, input int count, input string tag);
        logic [31:0] exp_pc = first_pc;
        int got = 0;
        int n   = 0;
        while (got < count && n < 40) begin
            if (if_valid) begin
                check({tag, "_pc"},    if_pc,    exp_pc);
                check({tag, "_instr"}, if_instr, ~exp_pc);
                check({tag, "_pc4"},   if_pc4,   exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            if (got < count) begin
                step();
                n++;
            end
        end
        check({tag, "_count"}, 32'(got), 32'(count));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc0;
        checks = 0;
        errors = 0;

        // Reset state
        do_reset(32'h0040_0000, 1);
        reset_n = 1'b0;
        step();
        check("rst_if_valid",    32'(if_valid),    32'd0);
        check("rst_imem_req",    32'(imem_req),    32'd0);
        check("rst_pc_enable",   32'(pc_enable),   32'd0);
        check("rst_if_misalign", 32'(if_misalign), 32'd0);
        check("rst_if_instr",    if_instr,         32'd0);
        check("rst_if_pc",       if_pc,            32'd0);
        check("rst_if_pc4",      if_pc4,           32'd0);
        reset_n = 1'b1;

        // Streaming with 1-cycle memory
        step();
        check("s_req",      32'(imem_req),  32'd1);
        check("s_addr",     imem_addr,      32'h0040_0000);
        check("s_pc_en",    32'(pc_enable), 32'd1);
        step();
        check("s_lat_gap",  32'(if_valid),  32'd0);
        step();
        check("s_first",    32'(if_valid),  32'd1);
        collect(32'h0040_0000, 4, "stream");

        // Decode stall: head holds, issue stops at DEPTH
        id_ready = 1'b0;
        acc0 = mem_accepts;
        repeat (5) step();
        check("stall_req",     32'(imem_req),  32'd0);
        check("stall_valid",   32'(if_valid),  32'd1);
        check("stall_pc",      if_pc,          32'h0040_000C);
        check("stall_instr",   if_instr,       32'hFFBF_FFF3);
        check("stall_accepts", 32'(mem_accepts - acc0 <= 2), 32'd1);
        id_ready = 1'b1;
        collect(32'h0040_000C, 3, "drain");

        // Flush with two requests outstanding on a 3-cycle memory
        do_reset(32'h0040_0000, 3);
        step();
        step();
        step();
        check("f3_full_req", 32'(imem_req), 32'd0);
        flush = 1'b1;
        flush_target = 32'h0040_0100;
        #1;
        check("f3_flush_pc_en", 32'(pc_enable), 32'd1);
        check("f3_flush_req",   32'(imem_req),  32'd0);
        step();
        flush = 1'b0;
        #1;
        check("f3_discard_blocks", 32'(imem_req), 32'd0);
        check("f3_cleared",        32'(if_valid), 32'd0);
        wait_valid(20, "f3");
        check("f3_pc",    if_pc,    32'h0040_0100);
        check("f3_instr", if_instr, 32'hFFBF_FEFF);
        check("f3_pc4",   if_pc4,   32'h0040_0104);

        // Flush coinciding with a response and a pop
        do_reset(32'h0040_0000, 1);
        step();
        step();
        step();
        check("fc_pre_valid",  32'(if_valid),    32'd1);
        check("fc_pre_rvalid", 32'(imem_rvalid), 32'd1);
        flush = 1'b1;
        flush_target = 32'h0040_0200;
        step();
        flush = 1'b0;
        #1;
        check("fc_cleared", 32'(if_valid), 32'd0);
        check("fc_req",     32'(imem_req), 32'd1);
        check("fc_addr",    imem_addr,     32'h0040_0200);
        step();
        check("fc_no_spurious", 32'(if_valid), 32'd0);
        step();
        check("fc_valid", 32'(if_valid), 32'd1);
        check("fc_pc",    if_pc,         32'h0040_0200);
        check("fc_instr", if_instr,      32'hFFBF_FDFF);

        // Misaligned PC
        do_reset(32'h0040_0002, 1);
        id_ready = 1'b0;
        step();
        check("mis_req",   32'(imem_req),  32'd0);
        check("mis_pc_en", 32'(pc_enable), 32'd1);
        step();
        check("mis_valid",    32'(if_valid),    32'd1);
        check("mis_flag",     32'(if_misalign), 32'd1);
        check("mis_pc",       if_pc,            32'h0040_0002);
        check("mis_instr",    if_instr,         32'h0000_0000);
        check("mis_pc4",      if_pc4,           32'h0040_0006);
        check("mis_req2",     32'(imem_req),    32'd0);
        check("mis_accepts",  32'(mem_accepts), 32'd0);

        // Address wrap and asynchronous reset mid-stream
        do_reset(32'hFFFF_FFF8, 1);
        step();
        step();
        step();
        check("wrap_pc_a",  if_pc,  32'hFFFF_FFF8);
        check("wrap_pc4_a", if_pc4, 32'hFFFF_FFFC);
        step();
        check("wrap_pc_b",    if_pc,         32'hFFFF_FFFC);
        check("wrap_pc4_b",   if_pc4,        32'h0000_0000);
        check("wrap_instr_b", if_instr,      32'h0000_0003);
        check("wrap_req",     32'(imem_req), 32'd1);
        check("wrap_addr",    imem_addr,     32'h0000_0000);
        #3;
        reset_n = 1'b0;
        #1;
        check("areset_valid", 32'(if_valid),  32'd0);
        check("areset_req",   32'(imem_req),  32'd0);
        check("areset_pc_en", 32'(pc_enable), 32'd0);
        step();
        reset_n = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
